prbs6_checker: RTL and testbench
================================

# prbs6_checker

Serial PRBS checker that sits directly downstream of the 6-stage LFSR pattern generator and consumes its one-bit output stream. It self-synchronises to the sequence b[n] = b[n-5] XOR b[n-6], which has a period of 63 bits. Once locked, it flags and counts bit errors and declares loss of lock on a burst of consecutive mismatches. It is the receive half of the team's link/BIST loopback.

## Interface
Parameters:
- LOCK_COUNT, 12: consecutive matches required in SEARCH to declare lock (range 1..63).
- UNLOCK_ERRS, 4: consecutive mismatches in LOCKED that force a return to SEARCH (range 1..15).
- ERR_W, 16: width of the error counter.
- CNT_W, 32: width of the checked-bit counter.

Ports:
- clk, in, 1: the single clock; every register updates on the rising edge.
- reset, in, 1: synchronous, active-high. Sampled on the rising edge of clk.
- bit_in, in, 1: serial bit from the generator's outs.
- bit_valid, in, 1: bit_in is accepted only on edges where this is 1.
- clear, in, 1: synchronous clear of err_cnt and bit_cnt. Has no effect on lock state.
- locked, out, 1: checker is in the LOCKED state.
- err_pulse, out, 1: one-cycle pulse for each mismatching bit accepted while LOCKED.
- err_cnt, out, ERR_W: saturating count of mismatches accepted while LOCKED.
- bit_cnt, out, CNT_W: saturating count of bits accepted while LOCKED.

## Operation
- The history register is h[5:0]. h[0] holds the newest bit and h[5] the oldest. expected = h[4] XOR h[5].
- On every accepted bit, h shifts: h <= {h[4:0], s}, where s is defined per state below.
- A fill counter (0..6) counts accepted bits since entering SEARCH. No comparison is made until fill = 6.

SEARCH state (reset state):
- s = bit_in.
- When fill = 6 and h != 0:
  - bit_in == expected: match_cnt increments.
  - otherwise: match_cnt becomes 0.
- When h == 0: match_cnt becomes 0. This prevents false lock on an all-zero stream.
- When a match brings match_cnt to LOCK_COUNT, go to LOCKED on that same edge. On entry, clear match_cnt and miss_cnt.

LOCKED state:
- s = expected. The checker free-runs its own reference, so a single corrupted input bit produces exactly one mismatch.
- Every accepted bit increments bit_cnt.
- bit_in != expected:
  - err_pulse is asserted the next cycle.
  - err_cnt increments.
  - miss_cnt increments.
- bit_in == expected: miss_cnt becomes 0.
- When miss_cnt reaches UNLOCK_ERRS, go to SEARCH. On that transition, clear fill, match_cnt and h.

General rules:
- Both counters saturate at all-ones and never wrap.
- bit_valid = 0: all state, history and counters hold. err_pulse = 0.
- clear and a counted event on the same edge: clear wins, so both counters become 0. err_pulse still fires for that error.
- A reset asserted mid-operation (in either state) returns everything to reset values on that edge. Counts are lost.

## Timing
- All outputs are registered. None of them is a combinational function of the inputs.
- Reset values: locked = 0, err_pulse = 0, err_cnt = 0, bit_cnt = 0. Internally: state = SEARCH, h = 0, fill = 0, match_cnt = 0, miss_cnt = 0.
- Latency: the edge that accepts bit k updates state and counters. locked, err_pulse and the counters are visible in the cycle that follows.
- Minimum time to lock from SEARCH: 6 + LOCK_COUNT accepted bits. With defaults, that is 18 bits.
- The bit that causes the transition to LOCKED is not counted in bit_cnt.
- Loss of lock: the UNLOCK_ERRS-th consecutive miss is counted in err_cnt. locked drops in the same cycle that its err_pulse is high.
- There is no backpressure. The checker accepts a bit on every edge with bit_valid = 1.

## Test plan
- Lock to the generator: release the generator and checker reset together, tie bit_valid = 1, and drive the stream 0,0,0,0,0,1,... from the generator -> locked rises after the 18th accepted bit. err_cnt stays 0 over 200 further bits, and bit_cnt = 200.
- Single error injection: with the checker locked, invert one bit -> exactly one err_pulse, err_cnt = 1, locked stays 1, and the following bits all match.
- Burst of errors: with the checker locked, invert 4 consecutive bits -> err_cnt = 4 and locked = 0 after the 4th bit. The checker then relocks 18 bits later with err_cnt still 4.
- Stuck input: drive bit_in = 0 with bit_valid = 1 for 500 cycles -> locked stays 0 and both counters stay 0. Repeat with bit_in = 1 -> still never locks (1 XOR 1 = 0 mismatches).
- Gaps and clear: with the checker locked, apply a bit_valid pattern of 1,0,0,1 -> bit_cnt advances by 2. Assert clear on the same edge as an injected error -> err_cnt = 0, bit_cnt = 0, err_pulse = 1.
- Reset mid-lock and saturation: with ERR_W = 2, inject 5 isolated errors -> err_cnt = 3. Then assert reset for 1 cycle -> all outputs return to 0 on the next cycle, and the checker relocks after 18 bits.

Source files
------------

// File: rtl/prbs6_checker.sv
// prbs6_checker: self-synchronising checker for the b[n] = b[n-5] ^ b[n-6] stream.
// Locks after LOCK_COUNT consecutive matches and counts errors and checked bits while locked.
`default_nettype none

module prbs6_checker #(
  parameter int unsigned LOCK_COUNT  = 12,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [0:0] S_SEARCH   = 1'b0;
  localparam logic [0:0] S_LOCKED   = 1'b1;
  localparam logic [5:0] LOCK_TGT   = 6'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_ERRS);
  localparam logic [2:0] FILL_FULL  = 3'd6;

  logic [0:0]       state_q,     state_d;
  logic [5:0]       h_q,         h_d;
  logic [2:0]       fill_q,      fill_d;
  logic [5:0]       match_q,     match_d;
  logic [3:0]       miss_q,      miss_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;

  logic expected;
  logic mismatch;

  assign expected = h_q[4] ^ h_q[5];
  assign mismatch = bit_in ^ expected;

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (bit_valid) begin
      case (state_q)
        S_SEARCH: begin
          h_d = {h_q[4:0], bit_in};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 3'd1;
          end else if ((h_q == 6'd0) || mismatch) begin
            // An all-zero history would self-match forever, so it never counts.
            match_d = 6'd0;
          end else if ((match_q + 6'd1) == LOCK_TGT) begin
            state_d = S_LOCKED;
            match_d = 6'd0;
            miss_d  = 4'd0;
          end else begin
            match_d = match_q + 6'd1;
          end
        end
        default: begin
          // Free-run the reference so one bad input bit yields exactly one error.
          h_d = {h_q[4:0], expected};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if ((miss_q + 4'd1) == UNLOCK_TGT) begin
              state_d = S_SEARCH;
              h_d     = 6'd0;
              fill_d  = 3'd0;
              match_d = 6'd0;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end else begin
            miss_d = 4'd0;
          end
        end
      endcase
    end

    if (clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SEARCH;
      h_q         <= 6'd0;
      fill_q      <= 3'd0;
      match_q     <= 6'd0;
      miss_q      <= 4'd0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked    = (state_q == S_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs6_checker.sv
// tb_prbs6_checker: directed bench for prbs6_checker with a reference PRBS6 source.
// A second instance with a 2-bit error counter shares the stimulus to exercise saturation.
`default_nettype none

module tb_prbs6_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;
  logic        sat_locked;
  logic        sat_err_pulse;
  logic [1:0]  sat_err_cnt;
  logic [31:0] sat_bit_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [5:0]  gh;
  int          gidx;
  logic        seen_lock;

  always #5 clk = ~clk;

  prbs6_checker dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs6_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .locked(sat_locked), .err_pulse(sat_err_pulse), .err_cnt(sat_err_cnt),
    .bit_cnt(sat_bit_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic clr);
    bit_in    = b;
    bit_valid = v;
    clear     = clr;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    clear     = 1'b0;
  endtask

  // Reference source: seed 0,0,0,0,0,1 then b[n] = b[n-5] ^ b[n-6].
  task automatic gen_next(output logic b);
    if (gidx < 6) b = (gidx == 5);
    else          b = gh[4] ^ gh[5];
    gh = {gh[4:0], b};
    gidx++;
  endtask

  task automatic send(input logic flip, input logic clr);
    logic b;
    gen_next(b);
    step(b ^ flip, 1'b1, clr);
  endtask

  task automatic send_n(input int n);
    repeat (n) send(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
    gh = 6'd0; gidx = 0; seen_lock = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 1'b0);
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);

    // Lock to the generator from power-up.
    reset = 1'b0;
    send_n(17);
    check("prelock_17", locked, 0);
    send(1'b0, 1'b0);
    check("lock_at_18", locked, 1);
    check("lock_bit_not_counted", bit_cnt, 0);
    send_n(200);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_bit_cnt", bit_cnt, 200);

    // Single injected error.
    send(1'b1, 1'b0);
    check("single_pulse", err_pulse, 1);
    check("single_err_cnt", err_cnt, 1);
    check("single_locked", locked, 1);
    send(1'b0, 1'b0);
    check("single_pulse_drop", err_pulse, 0);
    send_n(20);
    check("single_after_err", err_cnt, 1);
    check("single_after_bits", bit_cnt, 222);

    // Clear on a clean bit, then a 4-bit burst.
    send(1'b0, 1'b1);
    check("clear_err", err_cnt, 0);
    check("clear_bits", bit_cnt, 0);
    repeat (3) send(1'b1, 1'b0);
    check("burst3_locked", locked, 1);
    send(1'b1, 1'b0);
    check("burst4_unlock", locked, 0);
    check("burst4_pulse", err_pulse, 1);
    check("burst4_err", err_cnt, 4);
    check("burst_sat_err", sat_err_cnt, 3);
    send_n(17);
    check("relock_17", locked, 0);
    send(1'b0, 1'b0);
    check("relock_18", locked, 1);
    check("relock_err", err_cnt, 4);
    check("relock_bits", bit_cnt, 4);

    // Valid gaps: pattern 1,0,0,1 with an error on the first bit.
    send(1'b1, 1'b0);
    check("gap_err_pulse", err_pulse, 1);
    step(1'b1, 1'b0, 1'b0);
    check("gap_idle_pulse", err_pulse, 0);
    check("gap_idle_err", err_cnt, 5);
    step(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0);
    check("gap_bits", bit_cnt, 6);
    check("gap_locked", locked, 1);

    // Clear on the same edge as an error.
    send(1'b1, 1'b1);
    check("clr_err_err", err_cnt, 0);
    check("clr_err_bits", bit_cnt, 0);
    check("clr_err_pulse", err_pulse, 1);
    check("clr_err_locked", locked, 1);

    // Isolated errors: the 2-bit counter saturates at 3.
    repeat (5) begin
      send(1'b1, 1'b0);
      send_n(3);
    end
    check("iso_err", err_cnt, 5);
    check("iso_sat_err", sat_err_cnt, 3);
    check("iso_locked", locked, 1);

    // Reset mid-lock, then relock.
    reset = 1'b1;
    send(1'b0, 1'b0);
    reset = 1'b0;
    check("midrst_locked", locked, 0);
    check("midrst_pulse", err_pulse, 0);
    check("midrst_err", err_cnt, 0);
    check("midrst_bits", bit_cnt, 0);
    check("midrst_sat_err", sat_err_cnt, 0);
    send_n(17);
    check("midrst_relock_17", locked, 0);
    send(1'b0, 1'b0);
    check("midrst_relock_18", locked, 1);

    // Stuck-at-0 and stuck-at-1 input.
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    seen_lock = 1'b0;
    repeat (500) begin
      step(1'b0, 1'b1, 1'b0);
      if (locked) seen_lock = 1'b1;
    end
    check("stuck0_lock", seen_lock, 0);
    check("stuck0_err", err_cnt, 0);
    check("stuck0_bits", bit_cnt, 0);
    seen_lock = 1'b0;
    repeat (500) begin
      step(1'b1, 1'b1, 1'b0);
      if (locked) seen_lock = 1'b1;
    end
    check("stuck1_lock", seen_lock, 0);
    check("stuck1_err", err_cnt, 0);
    check("stuck1_bits", bit_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
